axis_slave_fifo: RTL and testbench

Receiving end of the accelerator's AXI4-Stream data path. It accepts input beats (weights and ifmaps) from the DMA on the S_AXIS port and buffers them in a small FIFO. It presents them first-word-fall-through to the data path, and reports per-packet beat counts and strobe faults for status registers. It mirrors the output-side `axis_master` and is gated by the control unit's `axis_en` / `axis_clear`.

---
 rtl/axis_slave_fifo.sv | 136 +++++++++++++
 tb/tb_axis_slave_fifo.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_slave_fifo.sv
// axis_slave_fifo: AXI4-Stream receive buffer. Accepts beats from the DMA,
// holds them in a small first-word-fall-through FIFO for the data path, and
// tracks per-packet beat counts and partial-strobe faults for status readback.
module axis_slave_fifo #(
  parameter int FIFO_DEPTH           = 4,
  parameter int C_S_AXIS_TDATA_WIDTH = 32,
  localparam int AW = $clog2(FIFO_DEPTH),
  localparam int W  = C_S_AXIS_TDATA_WIDTH,
  localparam int SW = C_S_AXIS_TDATA_WIDTH / 8
) (
  input  logic          S_AXIS_ACLK,
  input  logic          S_AXIS_ARESETN,
  input  logic          S_AXIS_TVALID,
  output logic          S_AXIS_TREADY,
  input  logic [W-1:0]  S_AXIS_TDATA,
  input  logic [SW-1:0] S_AXIS_TSTRB,
  input  logic          S_AXIS_TLAST,
  input  logic          axis_en,
  input  logic          axis_clear,
  output logic [W-1:0]  TDATA_out,
  output logic          TLAST_out,
  output logic          TVALID_out,
  input  logic          TREADY_in,
  output logic [AW:0]   fifo_count,
  output logic [15:0]   last_pkt_len,
  output logic          packet_done,
  output logic          strb_error,
  output logic [1:0]    rx_state_o
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    IN_PKT = 2'd1
  } rx_state_t;

  logic [W:0]     mem [FIFO_DEPTH];
  logic [AW:0]    wr_ptr;
  logic [AW:0]    rd_ptr;
  logic           full;
  logic           empty;
  logic           push;
  logic           pop;
  rx_state_t      state;
  logic [15:0]    beat_cnt;

  // Zero the bytes whose strobe is low so downstream never sees stale lanes.
  function automatic logic [W-1:0] mask_bytes(input logic [W-1:0] d,
                                               input logic [SW-1:0] s);
    logic [W-1:0] r;
    r = '0;
    for (int i = 0; i < SW; i++) begin
      r[i*8 +: 8] = s[i] ? d[i*8 +: 8] : 8'h00;
    end
    return r;
  endfunction

  // Saturating increment for the 16-bit beat counter.
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty = (wr_ptr == rd_ptr);

  // Ready ignores TVALID and any same-cycle pop: a full buffer never passes through.
  assign S_AXIS_TREADY = S_AXIS_ARESETN & axis_en & ~full & ~axis_clear;

  assign push = S_AXIS_TVALID & S_AXIS_TREADY;
  assign pop  = TVALID_out & TREADY_in & ~axis_clear;

  assign TVALID_out = ~empty;
  assign TDATA_out  = mem[rd_ptr[AW-1:0]][W-1:0];
  assign TLAST_out  = mem[rd_ptr[AW-1:0]][W];
  assign fifo_count = wr_ptr - rd_ptr;
  assign rx_state_o = state;

  // Storage: write the masked beat and its TLAST at the write pointer.
  always_ff @(posedge S_AXIS_ACLK or negedge S_AXIS_ARESETN) begin
    if (!S_AXIS_ARESETN) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (push) begin
      mem[wr_ptr[AW-1:0]] <= {S_AXIS_TLAST, mask_bytes(S_AXIS_TDATA, S_AXIS_TSTRB)};
    end
  end

  // Pointers: clear wins over push/pop; extra MSB distinguishes full from empty.
  always_ff @(posedge S_AXIS_ACLK or negedge S_AXIS_ARESETN) begin
    if (!S_AXIS_ARESETN) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (axis_clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // Packet FSM, beat counter, packet-done pulse and sticky strobe fault.
  always_ff @(posedge S_AXIS_ACLK or negedge S_AXIS_ARESETN) begin
    if (!S_AXIS_ARESETN) begin
      state        <= IDLE;
      beat_cnt     <= '0;
      last_pkt_len <= '0;
      packet_done  <= 1'b0;
      strb_error   <= 1'b0;
    end else if (axis_clear) begin
      state        <= IDLE;
      beat_cnt     <= '0;
      last_pkt_len <= '0;
      packet_done  <= 1'b0;
      strb_error   <= 1'b0;
    end else begin
      packet_done <= 1'b0;
      if (push) begin
        if (S_AXIS_TSTRB != {SW{1'b1}}) strb_error <= 1'b1;
        if (S_AXIS_TLAST) begin
          last_pkt_len <= sat_inc(beat_cnt);
          beat_cnt     <= '0;
          packet_done  <= 1'b1;
        end else begin
          beat_cnt <= sat_inc(beat_cnt);
        end
        case (state)
          IDLE:    if (!S_AXIS_TLAST) state <= IN_PKT;
          IN_PKT:  if (S_AXIS_TLAST)  state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_axis_slave_fifo.sv
// Directed testbench for axis_slave_fifo (FIFO_DEPTH=4, 32-bit data).
module tb_axis_slave_fifo;

  logic        clk;
  logic        rst_n;
  logic        tvalid;
  logic        tready;
  logic [31:0] tdata;
  logic [3:0]  tstrb;
  logic        tlast;
  logic        axis_en;
  logic        axis_clear;
  logic [31:0] tdata_out;
  logic        tlast_out;
  logic        tvalid_out;
  logic        tready_in;
  logic [2:0]  fifo_count;
  logic [15:0] last_pkt_len;
  logic        packet_done;
  logic        strb_error;
  logic [1:0]  rx_state;

  int tests;
  int fails;

  axis_slave_fifo #(
    .FIFO_DEPTH(4),
    .C_S_AXIS_TDATA_WIDTH(32)
  ) dut (
    .S_AXIS_ACLK   (clk),
    .S_AXIS_ARESETN(rst_n),
    .S_AXIS_TVALID (tvalid),
    .S_AXIS_TREADY (tready),
    .S_AXIS_TDATA  (tdata),
    .S_AXIS_TSTRB  (tstrb),
    .S_AXIS_TLAST  (tlast),
    .axis_en       (axis_en),
    .axis_clear    (axis_clear),
    .TDATA_out     (tdata_out),
    .TLAST_out     (tlast_out),
    .TVALID_out    (tvalid_out),
    .TREADY_in     (tready_in),
    .fifo_count    (fifo_count),
    .last_pkt_len  (last_pkt_len),
    .packet_done   (packet_done),
    .strb_error    (strb_error),
    .rx_state_o    (rx_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic test_reset();
    @(posedge clk); #1;
    axis_en = 1'b1; tready_in = 1'b0; tstrb = 4'hF;
    for (int i = 0; i < 3; i++) begin
      tvalid = 1'b1; tdata = 32'(32'hA0 + i); tlast = 1'b0;
      @(posedge clk); #1;
    end
    tvalid = 1'b0;
    tests++; if (fifo_count !== 3'd3) begin fails++; $display("FAIL reset_prefill count got %0d exp 3", fifo_count); end
    tests++; if (rx_state !== 2'd1) begin fails++; $display("FAIL reset_prefill state got %0d exp 1", rx_state); end
    #2 rst_n = 1'b0; #1;
    tests++; if (tready !== 1'b0) begin fails++; $display("FAIL reset_tready got %b exp 0", tready); end
    tests++; if (tvalid_out !== 1'b0) begin fails++; $display("FAIL reset_tvalid_out got %b exp 0", tvalid_out); end
    tests++; if (tdata_out !== 32'h0) begin fails++; $display("FAIL reset_tdata_out got %h exp 0", tdata_out); end
    tests++; if (tlast_out !== 1'b0) begin fails++; $display("FAIL reset_tlast_out got %b exp 0", tlast_out); end
    tests++; if (fifo_count !== 3'd0) begin fails++; $display("FAIL reset_count got %0d exp 0", fifo_count); end
    tests++; if (last_pkt_len !== 16'd0) begin fails++; $display("FAIL reset_len got %0d exp 0", last_pkt_len); end
    tests++; if (packet_done !== 1'b0) begin fails++; $display("FAIL reset_done got %b exp 0", packet_done); end
    tests++; if (strb_error !== 1'b0) begin fails++; $display("FAIL reset_strb got %b exp 0", strb_error); end
    tests++; if (rx_state !== 2'd0) begin fails++; $display("FAIL reset_state got %0d exp 0", rx_state); end
    @(posedge clk); #1;
    rst_n = 1'b1; #1;
    tests++; if (tready !== 1'b1) begin fails++; $display("FAIL reset_release_tready got %b exp 1", tready); end
    tests++; if (tvalid_out !== 1'b0) begin fails++; $display("FAIL reset_release_empty got %b exp 0", tvalid_out); end
  endtask

  task automatic test_stream();
    int nb, nout, pd;
    logic acc;
    nb = 0; nout = 0; pd = 0;
    @(posedge clk); #1;
    tready_in = 1'b1; tstrb = 4'hF;
    for (int c = 0; c < 20; c++) begin
      if (tvalid_out) begin
        tests++; if (tdata_out !== 32'(nout + 1)) begin fails++; $display("FAIL stream_data got %h exp %h", tdata_out, 32'(nout + 1)); end
        tests++; if (tlast_out !== 1'(nout == 7)) begin fails++; $display("FAIL stream_tlast beat %0d got %b", nout + 1, tlast_out); end
        nout++;
      end
      if (packet_done) begin
        pd++;
        tests++; if (last_pkt_len !== 16'd8) begin fails++; $display("FAIL stream_len got %0d exp 8", last_pkt_len); end
      end
      if (c == 3) begin
        tests++; if (rx_state !== 2'd1) begin fails++; $display("FAIL stream_mid_state got %0d exp 1", rx_state); end
      end
      if (nb < 8) begin tvalid = 1'b1; tdata = 32'(nb + 1); tlast = 1'(nb == 7); end
      else begin tvalid = 1'b0; tlast = 1'b0; end
      #1;
      acc = tvalid & tready;
      @(posedge clk); #1;
      if (acc) nb++;
    end
    tready_in = 1'b0;
    tests++; if (nout !== 8) begin fails++; $display("FAIL stream_beats_out got %0d exp 8", nout); end
    tests++; if (pd !== 1) begin fails++; $display("FAIL stream_done_pulses got %0d exp 1", pd); end
    tests++; if (rx_state !== 2'd0) begin fails++; $display("FAIL stream_end_state got %0d exp 0", rx_state); end
    tests++; if (last_pkt_len !== 16'd8) begin fails++; $display("FAIL stream_len_hold got %0d exp 8", last_pkt_len); end
  endtask

  task automatic test_back_pressure();
    int nb;
    logic acc;
    nb = 0;
    @(posedge clk); #1;
    tready_in = 1'b0; tstrb = 4'hF; tlast = 1'b0;
    for (int c = 0; c < 6; c++) begin
      tvalid = 1'b1; tdata = 32'(32'h10 + nb); #1;
      acc = tready;
      @(posedge clk); #1;
      if (acc) nb++;
    end
    tests++; if (nb !== 4) begin fails++; $display("FAIL bp_accepted got %0d exp 4", nb); end
    tests++; if (fifo_count !== 3'd4) begin fails++; $display("FAIL bp_count got %0d exp 4", fifo_count); end
    tests++; if (tready !== 1'b0) begin fails++; $display("FAIL bp_tready_full got %b exp 0", tready); end
    tready_in = 1'b1; #1;
    tests++; if (tready !== 1'b0) begin fails++; $display("FAIL bp_no_passthru got %b exp 0", tready); end
    tests++; if (tdata_out !== 32'h10) begin fails++; $display("FAIL bp_head got %h exp 10", tdata_out); end
    @(posedge clk); #1;
    tready_in = 1'b0; #1;
    tests++; if (tready !== 1'b1) begin fails++; $display("FAIL bp_tready_after_pop got %b exp 1", tready); end
    tests++; if (fifo_count !== 3'd3) begin fails++; $display("FAIL bp_count_after_pop got %0d exp 3", fifo_count); end
    @(posedge clk); #1;
    tvalid = 1'b0;
    tests++; if (fifo_count !== 3'd4) begin fails++; $display("FAIL bp_fifth_accept got %0d exp 4", fifo_count); end
    tready_in = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tests++; if (tdata_out !== 32'(32'h11 + i)) begin fails++; $display("FAIL bp_order got %h exp %h", tdata_out, 32'(32'h11 + i)); end
      @(posedge clk); #1;
    end
    tready_in = 1'b0;
    tests++; if (fifo_count !== 3'd0) begin fails++; $display("FAIL bp_drained got %0d exp 0", fifo_count); end
  endtask

  task automatic test_strobe();
    @(posedge clk); #1;
    tready_in = 1'b0;
    tvalid = 1'b1; tdata = 32'hAABBCCDD; tstrb = 4'b0101; tlast = 1'b0;
    @(posedge clk); #1;
    tdata = 32'h11223344; tstrb = 4'hF;
    tests++; if (tdata_out !== 32'h00BB00DD) begin fails++; $display("FAIL strb_mask got %h exp 00bb00dd", tdata_out); end
    tests++; if (strb_error !== 1'b1) begin fails++; $display("FAIL strb_set got %b exp 1", strb_error); end
    @(posedge clk); #1;
    tvalid = 1'b0; tready_in = 1'b1;
    @(posedge clk); #1;
    tests++; if (tdata_out !== 32'h11223344) begin fails++; $display("FAIL strb_full_beat got %h exp 11223344", tdata_out); end
    @(posedge clk); #1;
    tready_in = 1'b0;
    tests++; if (tvalid_out !== 1'b0) begin fails++; $display("FAIL strb_drained got %b exp 0", tvalid_out); end
    tests++; if (strb_error !== 1'b1) begin fails++; $display("FAIL strb_sticky got %b exp 1", strb_error); end
    axis_clear = 1'b1;
    @(posedge clk); #1;
    axis_clear = 1'b0;
    tests++; if (strb_error !== 1'b0) begin fails++; $display("FAIL strb_cleared got %b exp 0", strb_error); end
    tests++; if (rx_state !== 2'd0) begin fails++; $display("FAIL strb_clear_state got %0d exp 0", rx_state); end
    tests++; if (last_pkt_len !== 16'd0) begin fails++; $display("FAIL strb_clear_len got %0d exp 0", last_pkt_len); end
  endtask

  task automatic test_clear_collision();
    @(posedge clk); #1;
    tready_in = 1'b0; tstrb = 4'hF; tlast = 1'b0;
    tvalid = 1'b1; tdata = 32'h21;
    @(posedge clk); #1;
    tdata = 32'h22;
    @(posedge clk); #1;
    tests++; if (fifo_count !== 3'd2) begin fails++; $display("FAIL clr_prefill got %0d exp 2", fifo_count); end
    tdata = 32'h23; tready_in = 1'b1; axis_clear = 1'b1; #1;
    tests++; if (tready !== 1'b0) begin fails++; $display("FAIL clr_tready got %b exp 0", tready); end
    @(posedge clk); #1;
    tvalid = 1'b0; tready_in = 1'b0; axis_clear = 1'b0;
    tests++; if (fifo_count !== 3'd0) begin fails++; $display("FAIL clr_count got %0d exp 0", fifo_count); end
    tests++; if (tvalid_out !== 1'b0) begin fails++; $display("FAIL clr_tvalid_out got %b exp 0", tvalid_out); end
    tvalid = 1'b1; tdata = 32'h24;
    @(posedge clk); #1;
    tvalid = 1'b0;
    tests++; if (tdata_out !== 32'h24) begin fails++; $display("FAIL clr_next_beat got %h exp 24", tdata_out); end
    tests++; if (fifo_count !== 3'd1) begin fails++; $display("FAIL clr_next_count got %0d exp 1", fifo_count); end
    tready_in = 1'b1;
    @(posedge clk); #1;
    tready_in = 1'b0;
    tests++; if (fifo_count !== 3'd0) begin fails++; $display("FAIL clr_final_count got %0d exp 0", fifo_count); end
    axis_clear = 1'b1;
    @(posedge clk); #1;
    axis_clear = 1'b0;
  endtask

  task automatic test_single_beat_wrap();
    int nb, nout, pd, cyc;
    logic acc;
    nb = 0; nout = 0; pd = 0; cyc = 0;
    @(posedge clk); #1;
    tstrb = 4'hF;
    while ((nout < 10 || pd < 10) && cyc < 300) begin
      if (packet_done) begin
        pd++;
        tests++; if (last_pkt_len !== 16'd1) begin fails++; $display("FAIL single_len got %0d exp 1", last_pkt_len); end
      end
      if (nb < 10) begin tvalid = 1'b1; tdata = 32'(32'h100 + nb); tlast = 1'b1; end
      else begin tvalid = 1'b0; tlast = 1'b0; end
      tready_in = 1'($urandom_range(0, 1));
      #1;
      if (tvalid_out && tready_in) begin
        tests++; if (tdata_out !== 32'(32'h100 + nout)) begin fails++; $display("FAIL single_data got %h exp %h", tdata_out, 32'(32'h100 + nout)); end
        tests++; if (tlast_out !== 1'b1) begin fails++; $display("FAIL single_tlast got %b exp 1", tlast_out); end
        nout++;
      end
      acc = tvalid & tready;
      @(posedge clk); #1;
      cyc++;
      if (acc) nb++;
    end
    tvalid = 1'b0; tlast = 1'b0; tready_in = 1'b0;
    tests++; if (nout !== 10) begin fails++; $display("FAIL single_beats_out got %0d exp 10", nout); end
    tests++; if (pd !== 10) begin fails++; $display("FAIL single_done_pulses got %0d exp 10", pd); end
    tests++; if (rx_state !== 2'd0) begin fails++; $display("FAIL single_state got %0d exp 0", rx_state); end
  endtask

  initial begin
    tests = 0; fails = 0;
    rst_n = 1'b0; tvalid = 1'b0; tdata = '0; tstrb = 4'hF; tlast = 1'b0;
    axis_en = 1'b0; axis_clear = 1'b0; tready_in = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    test_reset();
    test_stream();
    test_back_pressure();
    test_strobe();
    test_clear_collision();
    test_single_beat_wrap();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
